// File: rtl/spi_board_sequencer_if.sv
// Board RAM write port driven by the SPI sequencer.
interface spi_board_sequencer_if #(
    parameter int AW = 5
);
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_row;
    logic [AW-1:0] wr_col;
    logic [7:0]    wr_data;

    modport master (
        output wr_en, wr_bank, wr_row, wr_col, wr_data
    );
    modport slave (
        input wr_en, wr_bank, wr_row, wr_col, wr_data
    );
endinterface

// File: rtl/spi_board_sequencer.sv
// Oversampling SPI receiver that writes cell bytes in raster order into a
// double-buffered N x N board RAM and counts mark cells per frame.
module spi_board_sequencer #(
    parameter int         N    = 32,
    parameter logic [7:0] MARK = 8'd74
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs,
    input  logic                 sdi,
    input  logic                 clear,
    spi_board_sequencer_if.master ram,
    output logic                 disp_bank,
    output logic                 frame_done,
    output logic [15:0]          num_marks,
    output logic                 busy
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    sclk_q;
    logic [1:0]    cs_q;
    logic [1:0]    sdi_q;
    logic          sclk_d;
    logic [7:0]    shreg;
    logic [2:0]    cnt;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [15:0]   count;
    logic          shift;

    assign shift = sclk_q[1] & ~sclk_d & ~cs_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= '0;
            cs_q   <= '1;
            sdi_q  <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[0], sclk};
            cs_q   <= {cs_q[0], cs};
            sdi_q  <= {sdi_q[0], sdi};
            sclk_d <= sclk_q[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            row         <= '0;
            col         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            num_marks   <= '0;
            disp_bank   <= 1'b0;
            ram.wr_en   <= 1'b0;
            ram.wr_bank <= 1'b1;
            ram.wr_row  <= '0;
            ram.wr_col  <= '0;
            ram.wr_data <= '0;
        end else begin
            ram.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            if (clear) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                row   <= '0;
                col   <= '0;
                count <= '0;
            end else begin
                // Shifter stays live in WRITE/DONE so early bits are kept
                if (shift) begin
                    shreg <= {shreg[6:0], sdi_q[1]};
                    cnt   <= cnt + 3'd1;
                end
                unique case (state)
                    IDLE: begin
                        if (shift) begin
                            state <= RECV;
                            busy  <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (cs_q[1]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else if (shift && cnt == 3'd7) begin
                            state <= WRITE;
                            busy  <= 1'b0;
                        end
                    end
                    WRITE: begin
                        ram.wr_en   <= 1'b1;
                        ram.wr_row  <= row;
                        ram.wr_col  <= col;
                        ram.wr_data <= shreg;
                        count <= count + 16'(shreg == MARK);
                        if (col == LAST) begin
                            col <= '0;
                            row <= row + AW'(1);
                        end else begin
                            col <= col + AW'(1);
                        end
                        if (row == LAST && col == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else if (cs_q[1]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RECV;
                            busy  <= 1'b1;
                        end
                    end
                    DONE: begin
                        frame_done  <= 1'b1;
                        num_marks   <= count;
                        count       <= '0;
                        disp_bank   <= ~disp_bank;
                        ram.wr_bank <= disp_bank;
                        row         <= '0;
                        col         <= '0;
                        if (cs_q[1]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RECV;
                            busy  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
